scan_chain_rx: RTL and testbench
================================

SCAN_CHAIN_RX -- requirements
Module: scan_chain_rx

Interface
REQ-001 Parameter: NTX_BITS, default 78, expected scan frame length in bits.
REQ-002 Parameter: TX_BITS_WIDTH, default 128, width of the received word.
REQ-003 Parameter: BIT_CNT_WIDTH, default 7, width of the bit counter.
REQ-004 Parameter: TIMEOUT_CYC, default 1024, number of clk cycles without a scan_phi rise before a frame is aborted.
REQ-005 Port: clk  in  1  single system clock; all logic is on this clock.
REQ-006 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port: scan_id  in  1  chain select; frames are accepted only while it is high; asynchronous to clk.
REQ-008 Port: scan_phi  in  1  shift phase clock; asynchronous.
REQ-009 Port: scan_phi_bar  in  1  non-overlapping complementary phase; asynchronous.
REQ-010 Port: scan_data_in  in  1  serial data, MSB first; asynchronous.
REQ-011 Port: scan_load_chip  in  1  frame load strobe; asynchronous.
REQ-012 Port: rx_bits  out  TX_BITS_WIDTH  last loaded frame, right-aligned, upper bits zero.
REQ-013 Port: rx_valid  out  1  one-cycle pulse when a new frame is loaded.
REQ-014 Port: rx_nbits  out  BIT_CNT_WIDTH  bit count of the last loaded frame.
REQ-015 Port: len_err  out  1  last loaded frame had rx_nbits != NTX_BITS.
REQ-016 Port: ovl_err  out  1  last loaded frame saw scan_phi and scan_phi_bar both high.
REQ-017 Port: timeout  out  1  one-cycle pulse when a frame is aborted by timeout.
REQ-018 Port: frame_cnt  out  16  count of rx_valid pulses, wraps modulo 2^16.
REQ-019 Port: rx_state  out  2  FSM state, for debug.

Function
REQ-020 Synchronisation: each of the five scan inputs SHALL pass through 2 flops; edge detection SHALL compare the synchronised value with a 1-cycle delayed copy.
REQ-021 FSM states: IDLE=00, SHIFT=01, LOAD=10, ABORT=11.
REQ-022 IDLE -> SHIFT when synchronised scan_id=1; on entry, clear the shift register, bit count and frame ovl flag.
REQ-023 In SHIFT, on a scan_phi rise the block SHALL do shreg <= {shreg[TX_BITS_WIDTH-2:0], scan_data_in_sync} and increment the bit count.
REQ-024 The bit count SHALL saturate at 2^BIT_CNT_WIDTH-1, and the frame SHALL then be flagged len_err.
REQ-025 In SHIFT, while scan_phi_sync && scan_phi_bar_sync, the frame ovl flag SHALL be set (sticky for the frame).
REQ-026 SHIFT -> LOAD on a scan_load_chip rise.
REQ-027 If a scan_phi rise occurs in the same cycle as the load rise, the bit SHALL be shifted first and included in the frame.
REQ-028 LOAD (1 cycle) SHALL:
  - register rx_bits = shreg masked to the lower rx_nbits bits;
  - set rx_nbits, len_err and ovl_err;
  - pulse rx_valid;
  - increment frame_cnt;
  - then go to SHIFT (clearing per REQ-022) if scan_id_sync=1, else IDLE.
REQ-029 Latency: a load edge first sampled by the first sync flop at cycle N SHALL give rx_valid=1 in cycle N+3.
REQ-030 SHIFT -> IDLE if scan_id_sync falls; the frame is discarded, there is no rx_valid and the outputs are unchanged.
REQ-031 A timeout counter SHALL reset on entry to SHIFT and on each scan_phi rise, and SHALL increment otherwise in SHIFT.
REQ-032 When the timeout counter reaches TIMEOUT_CYC-1, the FSM SHALL go SHIFT -> ABORT.
REQ-033 ABORT (1 cycle) SHALL pulse timeout, discard the frame, and return to IDLE.
REQ-034 A timeout SHALL NOT occur while the shift register is empty (bit count = 0); the counter SHALL hold.
REQ-035 rx_bits, rx_nbits, len_err and ovl_err SHALL hold until the next LOAD; there is no backpressure.
REQ-036 scan_phi rises and load rises in IDLE SHALL be ignored.

Reset
REQ-037 While reset_n=0, asynchronously:
  - state=IDLE, all sync flops=0;
  - rx_bits=0, rx_valid=0, rx_nbits=0, len_err=0, ovl_err=0, timeout=0, frame_cnt=0;
  - shreg, bit count and timeout counter = 0.
REQ-038 Assertion of reset_n=0 mid-frame SHALL discard the frame without producing rx_valid; release SHALL be synchronised to clk.

Verification
REQ-039 scan_id=1, 78 bits of 0x...A5C3 (MSB first, phi period 20 clk), load -> rx_valid once, rx_bits low 78 bits match, rx_nbits=78, len_err=0, ovl_err=0, frame_cnt=1.
REQ-040 The same frame with 77 bits -> rx_nbits=77, len_err=1, data right-aligned.
REQ-041 Phi and phi_bar held overlapping for 3 clk during a frame -> ovl_err=1 at load; the following clean frame -> ovl_err=0.
REQ-042 scan_id dropped after 40 bits -> no rx_valid, outputs hold previous values, state=IDLE within 3 cycles.
REQ-043 10 bits, then phi stops -> timeout pulse exactly TIMEOUT_CYC cycles after the last synchronised rise, no rx_valid.
REQ-044 reset_n pulsed low at bit 50 -> all outputs 0 immediately; a subsequent full frame is received correctly.

Source files
------------

// File: rtl/scan_chain_rx.sv
// Scan-chain frame receiver: samples an asynchronous two-phase scan interface on clk,
// assembles MSB-first frames and presents them as a right-aligned word with status flags.
module scan_chain_rx #(
  parameter int NTX_BITS      = 78,
  parameter int TX_BITS_WIDTH = 128,
  parameter int BIT_CNT_WIDTH = 7,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     scan_id,
  input  logic                     scan_phi,
  input  logic                     scan_phi_bar,
  input  logic                     scan_data_in,
  input  logic                     scan_load_chip,
  output logic [TX_BITS_WIDTH-1:0] rx_bits,
  output logic                     rx_valid,
  output logic [BIT_CNT_WIDTH-1:0] rx_nbits,
  output logic                     len_err,
  output logic                     ovl_err,
  output logic                     timeout,
  output logic [15:0]              frame_cnt,
  output logic [1:0]               rx_state
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BIT_CNT_WIDTH-1:0] NTX = BIT_CNT_WIDTH'(NTX_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    LOAD  = 2'b10,
    ABORT = 2'b11
  } state_t;

  state_t                   state, state_nxt;
  logic [1:0]               rst_pipe;
  logic                     rst_n_int;
  logic [4:0]               sync1, sync2;
  logic [1:0]               dly;
  logic                     id_s, phi_s, phib_s, data_s, load_s;
  logic                     phi_rise, load_rise;
  logic [TX_BITS_WIDTH-1:0] shreg, mask;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  logic                     sat, ovl;
  logic [TCNT_W-1:0]        tcnt;
  logic                     tmo_hit, enter_shift;

  // Reset asserts immediately but releases only on a clk edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n_int = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
    end else begin
      sync1 <= {scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip};
      sync2 <= sync1;
      dly   <= {sync2[3], sync2[0]};
    end
  end

  assign id_s      = sync2[4];
  assign phi_s     = sync2[3];
  assign phib_s    = sync2[2];
  assign data_s    = sync2[1];
  assign load_s    = sync2[0];
  assign phi_rise  = phi_s & ~dly[1];
  assign load_rise = load_s & ~dly[0];

  // The counter lands on TIMEOUT_CYC-1 on the same edge that enters ABORT.
  assign tmo_hit = (state == SHIFT) && !phi_rise && (bit_cnt != '0) &&
                   (tcnt == TCNT_W'(TIMEOUT_CYC - 2));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (id_s) state_nxt = SHIFT;
      SHIFT: begin
        if (!id_s)          state_nxt = IDLE;
        else if (load_rise) state_nxt = LOAD;
        else if (tmo_hit)   state_nxt = ABORT;
      end
      LOAD:    state_nxt = id_s ? SHIFT : IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_shift = (state_nxt == SHIFT) && (state != SHIFT);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) state <= IDLE;
    else            state <= state_nxt;
  end

  // A phi rise coinciding with the load rise is still shifted into this frame.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      shreg   <= '0;
      bit_cnt <= '0;
      sat     <= 1'b0;
      ovl     <= 1'b0;
      tcnt    <= '0;
    end else if (enter_shift) begin
      shreg   <= '0;
      bit_cnt <= '0;
      sat     <= 1'b0;
      ovl     <= 1'b0;
      tcnt    <= '0;
    end else if (state == SHIFT) begin
      if (phi_rise) begin
        shreg <= {shreg[TX_BITS_WIDTH-2:0], data_s};
        tcnt  <= '0;
        if (bit_cnt == '1) sat <= 1'b1;
        else               bit_cnt <= bit_cnt + 1'b1;
      end else if (bit_cnt != '0) begin
        tcnt <= tcnt + 1'b1;
      end
      if (phi_s && phib_s) ovl <= 1'b1;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < TX_BITS_WIDTH; i++) mask[i] = (i < int'(bit_cnt));
  end

  // rx_valid is a one-cycle pulse with no ready: the frame fields change only
  // together with that pulse and hold until the next one.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rx_bits   <= '0;
      rx_valid  <= 1'b0;
      rx_nbits  <= '0;
      len_err   <= 1'b0;
      ovl_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rx_valid <= (state == LOAD);
      if (state == LOAD) begin
        rx_bits   <= shreg & mask;
        rx_nbits  <= bit_cnt;
        len_err   <= sat || (bit_cnt != NTX);
        ovl_err   <= ovl;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign timeout  = (state == ABORT);
  assign rx_state = state;

endmodule

// File: tb/tb_scan_chain_rx.sv
// Randomised bench for scan_chain_rx: drives two-phase scan frames and checks loaded
// frames and timeouts against a word-level model through expected-response queues.
module tb_scan_chain_rx;

  localparam int T    = 64;
  localparam int NTX  = 78;
  localparam int E_W  = 185;
  localparam logic [127:0] KWORD = 128'h0000_0000_0000_1234_5678_9ABC_DEF0_A5C3;

  logic         clk = 1'b0;
  logic         reset_n, scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip;
  logic [127:0] rx_bits;
  logic         rx_valid, len_err, ovl_err, timeout;
  logic [6:0]   rx_nbits;
  logic [15:0]  frame_cnt;
  logic [1:0]   rx_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0]    model_cnt;
  logic [127:0]   last_bits;
  logic [6:0]     last_nbits;
  logic           last_len, last_ovl;
  logic [E_W-1:0] exp_q[$];
  logic [31:0]    to_q[$];

  scan_chain_rx #(
    .NTX_BITS(NTX), .TX_BITS_WIDTH(128), .BIT_CNT_WIDTH(7), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .scan_id(scan_id), .scan_phi(scan_phi),
    .scan_phi_bar(scan_phi_bar), .scan_data_in(scan_data_in),
    .scan_load_chip(scan_load_chip), .rx_bits(rx_bits), .rx_valid(rx_valid),
    .rx_nbits(rx_nbits), .len_err(len_err), .ovl_err(ovl_err), .timeout(timeout),
    .frame_cnt(frame_cnt), .rx_state(rx_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model: a loaded frame is the low n bits of the word sent MSB first
  task automatic push_frame(input logic [127:0] word, input int n, input bit ovl, input int c);
    logic [127:0] mask;
    mask       = (128'd1 << n) - 128'd1;
    model_cnt  = model_cnt + 16'd1;
    last_bits  = word & mask;
    last_nbits = 7'(n);
    last_len   = (n != NTX);
    last_ovl   = ovl;
    exp_q.push_back({32'(c + 4), model_cnt, last_ovl, last_len, last_nbits, last_bits});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_bits"},   rx_bits, 128'(0));
    check({tag, "_rx_valid"},  128'(rx_valid), 128'(0));
    check({tag, "_rx_nbits"},  128'(rx_nbits), 128'(0));
    check({tag, "_len_err"},   128'(len_err), 128'(0));
    check({tag, "_ovl_err"},   128'(ovl_err), 128'(0));
    check({tag, "_timeout"},   128'(timeout), 128'(0));
    check({tag, "_frame_cnt"}, 128'(frame_cnt), 128'(0));
    check({tag, "_rx_state"},  128'(rx_state), 128'(0));
  endtask

  task automatic reset_model();
    model_cnt  = '0;
    last_bits  = '0;
    last_nbits = '0;
    last_len   = 1'b0;
    last_ovl   = 1'b0;
  endtask

  // driver tasks
  task automatic start_frame();
    scan_id = 1'b1;
    tick(4);
  endtask

  task automatic end_frame();
    scan_id = 1'b0;
    tick(4);
  endtask

  // One phi period is 20 clk; ovl_bit overlaps phi/phi_bar for 3 clk at that bit.
  task automatic do_frame(input logic [127:0] word, input int n, input int ovl_bit,
                          input bit same_load, input bit do_load, input bit exp_to,
                          input int rst_at);
    int last_c;
    int i;
    bit ovl;
    last_c = cyc;
    ovl    = (ovl_bit >= 0) && (ovl_bit < n);
    for (int k = 0; k < n; k++) begin
      i = n - 1 - k;
      if (k == rst_at) begin
        scan_id = 1'b0; scan_phi = 1'b0; scan_phi_bar = 1'b1;
        scan_data_in = 1'b0; scan_load_chip = 1'b0;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        reset_model();
        tick(3);
        reset_n = 1'b1;
        tick(4);
        return;
      end
      scan_data_in = word[i];
      if (k == ovl_bit) begin
        tick(2);
        scan_phi = 1'b1;
        last_c   = cyc;
        tick(3);
        scan_phi_bar = 1'b0;
        tick(5);
      end else begin
        scan_phi_bar = 1'b0;
        tick(2);
        scan_phi = 1'b1;
        last_c   = cyc;
        if (k == n - 1 && same_load && do_load) begin
          scan_load_chip = 1'b1;
          push_frame(word, n, ovl, cyc);
        end
        tick(8);
      end
      scan_phi = 1'b0;
      tick(2);
      scan_phi_bar = 1'b1;
      tick(8);
    end
    if (do_load && !same_load) begin
      scan_load_chip = 1'b1;
      push_frame(word, n, ovl, cyc);
    end
    if (do_load) begin
      tick(4);
      scan_load_chip = 1'b0;
      tick(6);
    end
    if (exp_to) to_q.push_back(32'(last_c + 2 + T));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [E_W-1:0] e;
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rx_valid", 128'(rx_valid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("rx_bits",        rx_bits, e[127:0]);
        check("rx_nbits",       128'(rx_nbits), 128'(e[134:128]));
        check("len_err",        128'(len_err), 128'(e[135]));
        check("ovl_err",        128'(ovl_err), 128'(e[136]));
        check("frame_cnt",      128'(frame_cnt), 128'(e[152:137]));
        check("rx_valid_cycle", 128'(cyc), 128'(e[184:153]));
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      if (int'(e[184:153]) < cyc) begin
        check("missing_rx_valid", 128'(rx_valid), 128'(1));
        void'(exp_q.pop_front());
      end
    end
    if (timeout) begin
      if (to_q.size() == 0) check("unexpected_timeout", 128'(timeout), 128'(0));
      else check("timeout_cycle", 128'(cyc), 128'(to_q.pop_front()));
    end
    if (to_q.size() > 0 && int'(to_q[0]) < cyc) begin
      check("missing_timeout", 128'(timeout), 128'(1));
      void'(to_q.pop_front());
    end
  end

  initial begin
    logic [127:0] w;
    int n, ob;
    reset_n = 1'b1; scan_id = 1'b0; scan_phi = 1'b0; scan_phi_bar = 1'b1;
    scan_data_in = 1'b0; scan_load_chip = 1'b0;
    reset_model();
    #2 reset_n = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    tick(4);
    check("post_reset_state", 128'(rx_state), 128'(0));

    // directed frames, scan_id held high throughout
    start_frame();
    do_frame(KWORD, 78, -1, 1'b0, 1'b1, 1'b0, -1);
    do_frame(KWORD, 77, -1, 1'b0, 1'b1, 1'b0, -1);
    do_frame(KWORD, 78, 30, 1'b0, 1'b1, 1'b0, -1);
    do_frame(KWORD, 78, -1, 1'b0, 1'b1, 1'b0, -1);
    do_frame(KWORD, 78, -1, 1'b1, 1'b1, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0:       n = 77;
        1:       n = int'($urandom_range(2, 100));
        default: n = 78;
      endcase
      ob = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 2)) : -1;
      do_frame(w, n, ob, 1'($urandom_range(0, 1)), 1'b1, 1'b0, -1);
    end
    end_frame();

    // chain deselected mid-frame: frame discarded, outputs hold
    start_frame();
    do_frame({$urandom(), $urandom(), $urandom(), $urandom()}, 40, -1, 1'b0, 1'b0, 1'b0, -1);
    scan_id = 1'b0;
    tick(3);
    check("drop_rx_state",  128'(rx_state), 128'(0));
    check("drop_rx_bits",   rx_bits, last_bits);
    check("drop_rx_nbits",  128'(rx_nbits), 128'(last_nbits));
    check("drop_len_err",   128'(len_err), 128'(last_len));
    check("drop_ovl_err",   128'(ovl_err), 128'(last_ovl));
    check("drop_frame_cnt", 128'(frame_cnt), 128'(model_cnt));
    tick(4);

    // phi stops after 10 bits
    start_frame();
    do_frame({$urandom(), $urandom(), $urandom(), $urandom()}, 10, -1, 1'b0, 1'b0, 1'b1, -1);
    tick(T + 10);
    end_frame();

    // reset mid-frame, then a full frame
    start_frame();
    do_frame(KWORD, 78, -1, 1'b0, 1'b1, 1'b0, 50);
    start_frame();
    do_frame(KWORD, 78, -1, 1'b0, 1'b1, 1'b0, -1);
    end_frame();

    tick(10);
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    check("to_q_drained",  128'(to_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
